// File: rtl/control_defs.sv
// rtl/control_defs.sv - shared opcode, state, aluOp and aluSrcB encodings for the multicycle controller
package control_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000011;

  // Encoding is visible on the debug port, so values are pinned explicitly.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_RWB      = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXECUTE;
      OP_LW, OP_SW: return S_MEMADDR;
      OP_BEQ:       return S_BRANCH;
      default:      return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer
import control_defs::*;

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       retired,
  output logic       trap,
  output logic [3:0] state
);

  state_t cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE:     cur <= S_FETCH;
        S_FETCH:    if (memReady) cur <= S_DECODE;
        S_DECODE:   cur <= decode_next(opCode);
        S_MEMADDR:  cur <= (opCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (memReady) cur <= S_MEMWB;
        S_MEMWRITE: if (memReady) cur <= S_FETCH;
        S_EXECUTE:  cur <= S_RWB;
        S_MEMWB, S_RWB, S_BRANCH: cur <= S_FETCH;
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_IDLE;
      endcase
    end
  end

  // Decoded from the state register so reset clears every output asynchronously;
  // irWrite/pcWrite in FETCH and retired in MEMWRITE follow memReady directly.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_B;
    aluOp       = ALUOP_ADD;
    retired     = 1'b0;
    trap        = 1'b0;
    case (cur)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        aluOp   = ALUOP_ADD;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: begin
        aluSrcB = SRCB_IMM_SL2;
      end
      S_MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEMWB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
        retired  = 1'b1;
      end
      S_MEMWRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        retired  = memReady;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_B;
        aluOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
        retired  = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = 1'b1;
        retired     = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - trace-scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opCode = 6'd0;
  logic       memReady = 1'b0;
  logic       pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, retired, trap;
  logic [1:0] aluSrcB, aluOp;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSource(pcSource),
    .iorD(iorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .retired(retired), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp;
    logic       retired, trap;
  } outs_t;

  typedef struct {
    int    st;
    outs_t o;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  cur_e;
  outs_t act;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cnt_ret = 0, cnt_ir = 0, cnt_rw = 0, cnt_trap = 0;
  int    lat = 0, last_lat = 0;
  bit    in_instr = 0;

  assign act = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, retired, trap};

  // Output table per state number (0..10) as listed for the controller.
  function automatic outs_t model(int st, bit rdy);
    outs_t o = '0;
    case (st)
      1:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = rdy; o.pcWrite = rdy; end
      2:  o.aluSrcB = 2'b11;
      3:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
      4:  begin o.memRead = 1; o.iorD = 1; end
      5:  begin o.memToReg = 1; o.regWrite = 1; o.retired = 1; end
      6:  begin o.memWrite = 1; o.iorD = 1; o.retired = rdy; end
      7:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
      8:  begin o.regDst = 1; o.regWrite = 1; o.retired = 1; end
      9:  begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcWriteCond = 1; o.pcSource = 1; o.retired = 1; end
      10: o.trap = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_instr = 0;
    end else begin
      cnt_ret  += int'(retired);
      cnt_ir   += int'(irWrite);
      cnt_rw   += int'(regWrite);
      cnt_trap += int'(trap);
      if (!in_instr && state == 4'd1) begin
        in_instr = 1;
        lat = 0;
      end
      if (in_instr) begin
        lat++;
        if (retired) begin
          last_lat = lat;
          in_instr = 0;
        end
      end
    end
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      chk("trace_state", {28'd0, state}, cur_e.st);
      chk("trace_outputs", {15'd0, act}, {15'd0, cur_e.o});
    end
  end

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(1, 0));
  endfunction

  task automatic step(input int st, input bit rdy, input logic [5:0] op);
    exp_t e;
    memReady = rdy;
    opCode   = op;
    e.st = st;
    e.o  = model(st, rdy);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int exp_lat, input int exp_rw, input string tag);
    int r0, i0, w0;
    r0 = cnt_ret; i0 = cnt_ir; w0 = cnt_rw;
    for (int i = 0; i < fw; i++) step(1, 0, rnd_op());
    step(1, 1, rnd_op());
    step(2, rnd_bit(), op);
    case (op)
      6'd0: begin step(7, rnd_bit(), rnd_op()); step(8, rnd_bit(), rnd_op()); end
      6'd1: begin
        step(3, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(4, 0, rnd_op());
        step(4, 1, rnd_op());
        step(5, rnd_bit(), rnd_op());
      end
      6'd2: begin
        step(3, rnd_bit(), op);
        for (int i = 0; i < mw; i++) step(6, 0, rnd_op());
        step(6, 1, rnd_op());
      end
      default: step(9, rnd_bit(), rnd_op());
    endcase
    chk({tag, "_latency"}, last_lat, exp_lat);
    chk({tag, "_retired_pulses"}, cnt_ret - r0, 1);
    chk({tag, "_irwrite_cycles"}, cnt_ir - i0, 1);
    chk({tag, "_regwrite_cycles"}, cnt_rw - w0, exp_rw);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    reset = 1'b1;
    #1;
    chk({tag, "_async_state"}, {28'd0, state}, 0);
    chk({tag, "_async_outputs"}, {15'd0, act}, 0);
    e.st = 0;
    e.o  = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step(0, rnd_bit(), rnd_op());
    reset = 1'b0;
    step(0, rnd_bit(), rnd_op());
  endtask

  initial begin
    int r0, w0, t0;
    #1;
    chk("por_state", {28'd0, state}, 0);
    chk("por_outputs", {15'd0, act}, 0);
    @(posedge clk);
    #1;
    step(0, 0, 6'd0);
    reset = 1'b0;
    step(0, 1, 6'd0);

    run_instr(6'b000000, 0, 0, 4, 1, "rtype");
    run_instr(6'b000001, 2, 3, 10, 1, "load_wait");
    run_instr(6'b000001, 0, 0, 5, 1, "load");
    run_instr(6'b000010, 0, 0, 4, 0, "store");
    run_instr(6'b000010, 1, 2, 7, 0, "store_wait");
    run_instr(6'b000011, 0, 0, 3, 0, "branch");
    run_instr(6'b000000, 1, 0, 5, 1, "rtype_wait");

    // Abort a load while it waits in MEMREAD.
    r0 = cnt_ret; w0 = cnt_rw;
    step(1, 1, rnd_op());
    step(2, 1, 6'b000001);
    step(3, 1, 6'b000001);
    step(4, 0, rnd_op());
    step(4, 0, rnd_op());
    do_reset("abort");
    chk("abort_no_regwrite", cnt_rw - w0, 0);
    chk("abort_no_retire", cnt_ret - r0, 0);
    run_instr(6'b000000, 0, 0, 4, 1, "after_abort");

    // Undefined opcode parks in TRAP regardless of inputs.
    r0 = cnt_ret; t0 = cnt_trap;
    step(1, 1, rnd_op());
    step(2, rnd_bit(), 6'b101010);
    for (int i = 0; i < 22; i++) step(10, rnd_bit(), rnd_op());
    chk("trap_cycles", cnt_trap - t0, 22);
    chk("trap_no_retire", cnt_ret - r0, 0);
    do_reset("trap_reset");
    chk("trap_cleared", {31'd0, trap}, 0);
    run_instr(6'b000011, 0, 0, 3, 0, "after_trap");

    chk("trace_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
